// File: rtl/comm_frame_assembler_if.sv
// Bundle of the receive, command, and response signals between the UART-facing
// frame assembler and its surroundings.
interface comm_frame_assembler_if;
  // Handshakes: the receiver holds rx_rdy/rx_data until it sees the clr_rx_rdy pulse.
  // cmd_rdy stays high until clr_cmd_rdy. send_resp, trmt, tx_done, frm_drop and resp_ovf
  // are each a 1-cycle strobe.
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        frm_drop;
  logic [7:0]  resp;
  logic        send_resp;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        resp_ovf;
  // Debug view: rx_state_dbg 0=WAIT_CMD 1=WAIT_HI 2=WAIT_LO.
  logic [1:0]  rx_state_dbg;
  logic        tx_busy_dbg;
  logic        buf_full_dbg;

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    output clr_rx_rdy, cmd, data, cmd_rdy, frm_drop, tx_data, trmt, resp_ovf,
           rx_state_dbg, tx_busy_dbg, buf_full_dbg
  );

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    input  clr_rx_rdy, cmd, data, cmd_rdy, frm_drop, tx_data, trmt, resp_ovf,
           rx_state_dbg, tx_busy_dbg, buf_full_dbg
  );
endinterface

// File: rtl/comm_frame_assembler.sv
// Packs cmd/data_hi/data_lo UART bytes into an atomically published command frame and
// returns single-byte responses through the UART transmitter with a 1-deep buffer.
module comm_frame_assembler #(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int TO_W        = 20
) (
  input logic                   clk,
  input logic                   rst,
  comm_frame_assembler_if.slave bus
);
  typedef enum logic [1:0] {WAIT_CMD = 2'd0, WAIT_HI = 2'd1, WAIT_LO = 2'd2} rx_state_e;
  typedef enum logic {TX_IDLE = 1'b0, TX_BUSY = 1'b1} tx_state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX  = '1;

  rx_state_e   rx_state_q, rx_state_d;
  logic [7:0]  cmd_sh_q, cmd_sh_d;
  logic [7:0]  data_hi_sh_q, data_hi_sh_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        clr_rx_rdy_q, clr_rx_rdy_d;
  logic        frm_drop_q, frm_drop_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  tx_state_e   tx_state_q, tx_state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        trmt_q, trmt_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
  logic        resp_ovf_q, resp_ovf_d;

  logic        accept;

  // The receiver still shows the old byte while clr_rx_rdy is high, so that cycle is blind.
  assign accept = bus.rx_rdy && !clr_rx_rdy_q;

  always_comb begin
    rx_state_d   = rx_state_q;
    cmd_sh_d     = cmd_sh_q;
    data_hi_sh_d = data_hi_sh_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    cmd_rdy_d    = cmd_rdy_q;
    to_cnt_d     = to_cnt_q;
    clr_rx_rdy_d = 1'b0;
    frm_drop_d   = 1'b0;
    if (bus.clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (accept) begin
      clr_rx_rdy_d = 1'b1;
      to_cnt_d     = '0;
      unique case (rx_state_q)
        WAIT_CMD: begin
          cmd_sh_d   = bus.rx_data;
          cmd_rdy_d  = 1'b0;
          rx_state_d = WAIT_HI;
        end
        WAIT_HI: begin
          data_hi_sh_d = bus.rx_data;
          rx_state_d   = WAIT_LO;
        end
        WAIT_LO: begin
          cmd_d      = cmd_sh_q;
          data_d     = {data_hi_sh_q, bus.rx_data};
          cmd_rdy_d  = 1'b1;
          rx_state_d = WAIT_CMD;
        end
        default: rx_state_d = WAIT_CMD;
      endcase
    end else if (rx_state_q != WAIT_CMD) begin
      if (to_cnt_q == TO_LAST) begin
        rx_state_d = WAIT_CMD;
        frm_drop_d = 1'b1;
        to_cnt_d   = '0;
      end else if (to_cnt_q != TO_MAX) begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    trmt_d     = 1'b0;
    resp_ovf_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.send_resp) begin
          tx_data_d  = bus.resp;
          trmt_d     = 1'b1;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (bus.tx_done) begin
          // Completion frees the slot first, so a simultaneous request never overflows.
          if (buf_full_q) begin
            tx_data_d  = buf_q;
            trmt_d     = 1'b1;
            buf_full_d = bus.send_resp;
            if (bus.send_resp) buf_d = bus.resp;
          end else if (bus.send_resp) begin
            tx_data_d = bus.resp;
            trmt_d    = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else if (bus.send_resp) begin
          if (buf_full_q) begin
            resp_ovf_d = 1'b1;
          end else begin
            buf_d      = bus.resp;
            buf_full_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q   <= WAIT_CMD;
      cmd_sh_q     <= '0;
      data_hi_sh_q <= '0;
      cmd_q        <= '0;
      data_q       <= '0;
      cmd_rdy_q    <= 1'b0;
      clr_rx_rdy_q <= 1'b0;
      frm_drop_q   <= 1'b0;
      to_cnt_q     <= '0;
      tx_state_q   <= TX_IDLE;
      tx_data_q    <= '0;
      trmt_q       <= 1'b0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      resp_ovf_q   <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      cmd_sh_q     <= cmd_sh_d;
      data_hi_sh_q <= data_hi_sh_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      cmd_rdy_q    <= cmd_rdy_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      frm_drop_q   <= frm_drop_d;
      to_cnt_q     <= to_cnt_d;
      tx_state_q   <= tx_state_d;
      tx_data_q    <= tx_data_d;
      trmt_q       <= trmt_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      resp_ovf_q   <= resp_ovf_d;
    end
  end

  assign bus.clr_rx_rdy   = clr_rx_rdy_q;
  assign bus.cmd          = cmd_q;
  assign bus.data         = data_q;
  assign bus.cmd_rdy      = cmd_rdy_q;
  assign bus.frm_drop     = frm_drop_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.trmt         = trmt_q;
  assign bus.resp_ovf     = resp_ovf_q;
  assign bus.rx_state_dbg = rx_state_q;
  assign bus.tx_busy_dbg  = (tx_state_q == TX_BUSY);
  assign bus.buf_full_dbg = buf_full_q;
endmodule

// File: tb/tb_comm_frame_assembler.sv
// Directed bench for comm_frame_assembler: a queue-based frame/response model checked
// against the DUT every cycle, plus literal spot checks.
module tb_comm_frame_assembler;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  comm_frame_assembler_if bus();
  comm_frame_assembler #(.TIMEOUT_CYC(TO), .TO_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int clr_pulses = 0;
  bit chk_en = 1'b0;

  logic [7:0]  exp_cmd = '0;
  logic [15:0] exp_data = '0;
  logic [7:0]  exp_tx = '0;
  logic        exp_cmd_rdy = 1'b0, exp_clr = 1'b0, exp_drop = 1'b0, exp_trmt = 1'b0, exp_ovf = 1'b0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int          gap = 0;
  bit          tx_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes collect in rx_q until three make a frame; responses queue behind one in flight.
  task automatic tick();
    logic i_rst, i_rdy, i_clrc, i_send, i_done, prev_clr, done_frame;
    logic [7:0] i_data, i_resp;
    i_rst = rst; i_rdy = bus.rx_rdy; i_data = bus.rx_data; i_clrc = bus.clr_cmd_rdy;
    i_send = bus.send_resp; i_resp = bus.resp; i_done = bus.tx_done;
    @(posedge clk);
    #1;
    prev_clr = exp_clr;
    done_frame = 1'b0;
    exp_clr = 1'b0; exp_drop = 1'b0; exp_trmt = 1'b0; exp_ovf = 1'b0;
    if (i_rst) begin
      exp_cmd = '0; exp_data = '0; exp_cmd_rdy = 1'b0; exp_tx = '0;
      rx_q.delete(); exp_q.delete(); gap = 0; tx_busy = 1'b0;
    end else begin
      if (i_rdy && !prev_clr) begin
        exp_clr = 1'b1;
        gap = 0;
        rx_q.push_back(i_data);
        if (rx_q.size() == 1) exp_cmd_rdy = 1'b0;
        if (rx_q.size() == 3) begin
          exp_cmd = rx_q[0];
          exp_data = {rx_q[1], rx_q[2]};
          rx_q.delete();
          done_frame = 1'b1;
        end
      end else if (rx_q.size() != 0) begin
        gap++;
        if (gap == TO) begin
          rx_q.delete();
          gap = 0;
          exp_drop = 1'b1;
        end
      end
      if (i_clrc) exp_cmd_rdy = 1'b0;
      if (done_frame) exp_cmd_rdy = 1'b1;
      if (i_done && tx_busy) begin
        if (exp_q.size() != 0) begin
          exp_tx = exp_q.pop_front();
          exp_trmt = 1'b1;
        end else begin
          tx_busy = 1'b0;
        end
      end
      if (i_send) begin
        if (!tx_busy) begin
          exp_tx = i_resp; exp_trmt = 1'b1; tx_busy = 1'b1;
        end else if (exp_q.size() == 0) begin
          exp_q.push_back(i_resp);
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd", 32'(bus.cmd), 32'(exp_cmd));
      chk("data", 32'(bus.data), 32'(exp_data));
      chk("cmd_rdy", 32'(bus.cmd_rdy), 32'(exp_cmd_rdy));
      chk("clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'(exp_clr));
      chk("frm_drop", 32'(bus.frm_drop), 32'(exp_drop));
      chk("tx_data", 32'(bus.tx_data), 32'(exp_tx));
      chk("trmt", 32'(bus.trmt), 32'(exp_trmt));
      chk("resp_ovf", 32'(bus.resp_ovf), 32'(exp_ovf));
      if (bus.clr_rx_rdy === 1'b1) clr_pulses++;
    end
  end

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Receiver holds the byte through the clr_rx_rdy cycle, then drops rx_rdy.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_rdy = 1'b1; bus.rx_data = b;
    tick();
    tick();
    bus.rx_rdy = 1'b0;
  endtask

  task automatic pulse_resp(input logic [7:0] r);
    bus.send_resp = 1'b1; bus.resp = r;
    tick();
    bus.send_resp = 1'b0;
  endtask

  task automatic pulse_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.clr_cmd_rdy = 1'b0;
    bus.resp = '0; bus.send_resp = 1'b0; bus.tx_done = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'h0);
    chk("rst_rx_state", 32'(bus.rx_state_dbg), 32'h0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
    idle(3);

    // Basic frame with gaps
    clr_pulses = 0;
    send_byte(8'h05); idle(10);
    send_byte(8'h01); idle(10);
    send_byte(8'hFF);
    chk("t1_cmd", 32'(bus.cmd), 32'h05);
    chk("t1_data", 32'(bus.data), 32'h01FF);
    chk("t1_cmd_rdy", 32'(bus.cmd_rdy), 32'h1);
    chk("t1_clr_pulses", 32'(clr_pulses), 32'd3);
    idle(3);

    // New byte0 clears cmd_rdy but leaves the published frame alone
    send_byte(8'h02);
    chk("t2_rdy_cleared", 32'(bus.cmd_rdy), 32'h0);
    chk("t2_cmd_held", 32'(bus.cmd), 32'h05);
    chk("t2_data_held", 32'(bus.data), 32'h01FF);
    send_byte(8'h12); idle(2);
    send_byte(8'h34);
    chk("t2_cmd", 32'(bus.cmd), 32'h02);
    chk("t2_data", 32'(bus.data), 32'h1234);
    bus.clr_cmd_rdy = 1'b1; tick(); bus.clr_cmd_rdy = 1'b0;
    chk("t2_ack", 32'(bus.cmd_rdy), 32'h0);

    // Frame completion and acknowledge in the same cycle: set wins
    send_byte(8'h07); send_byte(8'hAB);
    bus.rx_rdy = 1'b1; bus.rx_data = 8'hCD; bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    tick();
    bus.rx_rdy = 1'b0;
    chk("t2_set_wins", 32'(bus.cmd_rdy), 32'h1);
    chk("t2_data_abcd", 32'(bus.data), 32'hABCD);
    idle(2);

    // Timeout discards a partial frame
    send_byte(8'h06);
    idle(TO - 2);
    chk("t3_pre_drop", 32'(bus.frm_drop), 32'h0);
    chk("t3_pre_state", 32'(bus.rx_state_dbg), 32'h1);
    tick();
    chk("t3_drop", 32'(bus.frm_drop), 32'h1);
    chk("t3_state", 32'(bus.rx_state_dbg), 32'h0);
    chk("t3_cmd_kept", 32'(bus.cmd), 32'h07);
    tick();
    chk("t3_drop_end", 32'(bus.frm_drop), 32'h0);
    send_byte(8'h06); send_byte(8'h00); send_byte(8'h00);
    chk("t3_cmd", 32'(bus.cmd), 32'h06);
    chk("t3_data", 32'(bus.data), 32'h0000);

    // Byte arriving on the expiry cycle is accepted
    send_byte(8'h09);
    idle(TO - 2);
    send_byte(8'h88);
    chk("t3_no_drop", 32'(bus.rx_state_dbg), 32'h2);
    send_byte(8'h99);
    chk("t3_edge_data", 32'(bus.data), 32'h8899);
    idle(2);

    // Single response
    pulse_resp(8'hA5);
    chk("t4_trmt", 32'(bus.trmt), 32'h1);
    chk("t4_tx_data", 32'(bus.tx_data), 32'hA5);
    idle(5);
    pulse_done();
    chk("t4_idle", 32'(bus.tx_busy_dbg), 32'h0);
    idle(2);

    // Buffer fill and overflow
    pulse_resp(8'hA5); idle(1);
    pulse_resp(8'h5A);
    pulse_resp(8'h33);
    chk("t5_ovf", 32'(bus.resp_ovf), 32'h1);
    idle(3);
    pulse_done();
    chk("t5_trmt_buf", 32'(bus.trmt), 32'h1);
    chk("t5_tx_buf", 32'(bus.tx_data), 32'h5A);
    // Buffer full, tx_done and send_resp together: no overflow
    pulse_resp(8'h44); idle(2);
    bus.tx_done = 1'b1; bus.send_resp = 1'b1; bus.resp = 8'h66;
    tick();
    bus.tx_done = 1'b0; bus.send_resp = 1'b0;
    chk("t5_swap_tx", 32'(bus.tx_data), 32'h44);
    chk("t5_swap_buf", 32'(bus.buf_full_dbg), 32'h1);
    idle(2); pulse_done(); idle(2); pulse_done();
    chk("t5_idle", 32'(bus.tx_busy_dbg), 32'h0);
    idle(2);

    // Reset mid-frame and mid-transmit
    send_byte(8'h11); send_byte(8'h22);
    pulse_resp(8'h77); pulse_resp(8'h44);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("t6_cmd", 32'(bus.cmd), 32'h0);
    chk("t6_data", 32'(bus.data), 32'h0);
    chk("t6_tx_data", 32'(bus.tx_data), 32'h0);
    chk("t6_busy", 32'(bus.tx_busy_dbg), 32'h0);
    chk("t6_buf", 32'(bus.buf_full_dbg), 32'h0);
    chk("t6_state", 32'(bus.rx_state_dbg), 32'h0);
    pulse_done();
    idle(2);
    bus.send_resp = 1'b1; bus.resp = 8'hC3;
    send_byte(8'h03);
    bus.send_resp = 1'b0;
    send_byte(8'hBE); send_byte(8'hEF);
    chk("t6_cmd_new", 32'(bus.cmd), 32'h03);
    chk("t6_data_new", 32'(bus.data), 32'hBEEF);
    chk("t6_tx_new", 32'(bus.tx_data), 32'hC3);
    pulse_done();
    idle(3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
